memory_ctrl: RTL and testbench

- Parametrised successor to the single-port memory top: a synchronous single-port RAM with a built-in clear sweep.
- After reset, and on demand, the RAM fills every location with INIT_VALUE; `busy` is high throughout the sweep.
- Reads are registered and qualified by `rd_valid`. Read/write collision ordering is set by a parameter.
- Accesses attempted while busy are rejected and flagged.
- Sits between the CPU bus interface and the system RAM.

---
 rtl/memory_ctrl.sv | 117 +++++++++++
 tb/tb_memory_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// Single-port synchronous RAM with a built-in clear sweep that fills every word
// with INIT_VALUE after reset and on request; reads are registered with a valid pulse.
module memory_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    RD_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_enable,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  req_dropped
);

  localparam int                DEPTH    = 2 ** ADDR_WIDTH;
  localparam int                CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic                    busy_q, busy_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    req_dropped_q, req_dropped_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_fire;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    busy_d        = busy_q;
    rd_valid_d    = 1'b0;
    req_dropped_d = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = addr;
    mem_wdata     = wr_data;
    rd_fire       = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we        = 1'b1;
        mem_waddr     = clr_cnt_q[ADDR_WIDTH-1:0];
        mem_wdata     = INIT_VALUE;
        req_dropped_d = rd_enable | wr_enable | clear_req;
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        // clear_req wins over any access issued on the same edge
        if (clear_req) begin
          state_d       = CLEAR;
          busy_d        = 1'b1;
          clr_cnt_d     = '0;
          req_dropped_d = rd_enable | wr_enable;
        end else begin
          mem_we     = wr_enable;
          rd_fire    = rd_enable;
          rd_valid_d = rd_enable;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= '0;
      busy_q        <= 1'b1;
      rd_valid_q    <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      busy_q        <= busy_d;
      rd_valid_q    <= rd_valid_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  // Collision ordering: write-first forwards wr_data, read-first sees the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      if (RD_MODE != 0 && wr_enable) rd_data_q <= wr_data;
      else                           rd_data_q <= mem[addr];
    end
  end

  // RAM array has no reset; reset only restarts the sweep
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy        = busy_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign req_dropped = req_dropped_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl: two instances (read-first and write-first) share stimulus.
module tb_memory_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam logic [DW-1:0] INIT = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_enable = 1'b0, wr_enable = 1'b0, clear_req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic          busy0, rd_valid0, req_dropped0;
  logic [DW-1:0] rd_data0;
  logic          busy1, rd_valid1, req_dropped1;
  logic [DW-1:0] rd_data1;

  int total = 0;
  int passed = 0;

  memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT), .RD_MODE(0)) u_rf (
    .clk(clk), .reset(reset), .rd_enable(rd_enable), .wr_enable(wr_enable),
    .addr(addr), .wr_data(wr_data), .clear_req(clear_req),
    .busy(busy0), .rd_data(rd_data0), .rd_valid(rd_valid0), .req_dropped(req_dropped0));

  memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT), .RD_MODE(1)) u_wf (
    .clk(clk), .reset(reset), .rd_enable(rd_enable), .wr_enable(wr_enable),
    .addr(addr), .wr_data(wr_data), .clear_req(clear_req),
    .busy(busy1), .rd_data(rd_data1), .rd_valid(rd_valid1), .req_dropped(req_dropped1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_enable = 1'b1; addr = a; wr_data = d;
    tick();
    wr_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (busy0 !== 1'b1) $display("FAIL reset_busy: got %b exp 1", busy0); else passed++;
    total++; if (rd_valid0 !== 1'b0) $display("FAIL reset_rd_valid: got %b exp 0", rd_valid0); else passed++;
    total++; if (req_dropped0 !== 1'b0) $display("FAIL reset_dropped: got %b exp 0", req_dropped0); else passed++;
    total++; if (rd_data0 !== 8'h00) $display("FAIL reset_rd_data: got %h exp 00", rd_data0); else passed++;
    total++; if (busy1 !== 1'b1) $display("FAIL reset_busy_wf: got %b exp 1", busy1); else passed++;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if (busy0 !== (k < 16)) $display("FAIL sweep_busy edge %0d: got %b exp %b", k, busy0, (k < 16));
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      rd_enable = 1'b1; addr = AW'(i);
      tick();
      rd_enable = 1'b0;
      total++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== INIT)
        $display("FAIL init_read addr %0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid0, rd_data0, INIT);
      else passed++;
      tick();
      total++;
      if (rd_valid0 !== 1'b0) $display("FAIL init_read_pulse addr %0d: got v=%b exp 0", i, rd_valid0);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    do_write(4'd5, 8'h3C);
    rd_enable = 1'b1; addr = 4'd5;
    tick();
    total++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 8'h3C)
      $display("FAIL wr_rd_5: got v=%b d=%h exp v=1 d=3c", rd_valid0, rd_data0);
    else passed++;
    addr = 4'd6;
    tick();
    rd_enable = 1'b0;
    total++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== INIT)
      $display("FAIL rd_6: got v=%b d=%h exp v=1 d=a5", rd_valid0, rd_data0);
    else passed++;
    tick();
    total++;
    if (rd_valid0 !== 1'b0 || req_dropped0 !== 1'b0)
      $display("FAIL idle_after_rd: got v=%b drop=%b exp 0/0", rd_valid0, req_dropped0);
    else passed++;
  endtask

  task automatic test_collision();
    do_write(4'd7, 8'h11);
    rd_enable = 1'b1; wr_enable = 1'b1; addr = 4'd7; wr_data = 8'h22;
    tick();
    wr_enable = 1'b0;
    total++;
    if (rd_data0 !== 8'h11) $display("FAIL coll_read_first: got %h exp 11", rd_data0); else passed++;
    total++;
    if (rd_data1 !== 8'h22) $display("FAIL coll_write_first: got %h exp 22", rd_data1); else passed++;
    tick();
    rd_enable = 1'b0;
    total++;
    if (rd_data0 !== 8'h22 || rd_data1 !== 8'h22)
      $display("FAIL coll_reread: got %h/%h exp 22/22", rd_data0, rd_data1);
    else passed++;
  endtask

  task automatic test_clear();
    logic [DW-1:0] held;
    do_write(4'd3, 8'h55);
    held = rd_data0;
    clear_req = 1'b1; wr_enable = 1'b1; addr = 4'd3; wr_data = 8'h66;
    tick();
    clear_req = 1'b0; wr_enable = 1'b0;
    total++;
    if (busy0 !== 1'b1 || req_dropped0 !== 1'b1)
      $display("FAIL clear_start: got busy=%b drop=%b exp 1/1", busy0, req_dropped0);
    else passed++;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin wr_enable = 1'b1; rd_enable = 1'b1; addr = 4'd9; wr_data = 8'h77; end
      tick();
      wr_enable = 1'b0; rd_enable = 1'b0;
      total++;
      if (busy0 !== (k < 16)) $display("FAIL clear_busy edge %0d: got %b exp %b", k, busy0, (k < 16));
      else passed++;
      if (k == 3 || k == 4) begin
        total++;
        if (req_dropped0 !== (k == 3) || rd_valid0 !== 1'b0 || rd_data0 !== held)
          $display("FAIL clear_drop edge %0d: got drop=%b v=%b d=%h exp drop=%b v=0 d=%h",
                   k, req_dropped0, rd_valid0, rd_data0, (k == 3), held);
        else passed++;
      end
    end
    rd_enable = 1'b1; addr = 4'd3;
    tick();
    total++;
    if (rd_data0 !== INIT) $display("FAIL clear_addr3: got %h exp a5", rd_data0); else passed++;
    addr = 4'd9;
    tick();
    rd_enable = 1'b0;
    total++;
    if (rd_data0 !== INIT) $display("FAIL clear_addr9: got %h exp a5", rd_data0); else passed++;
  endtask

  task automatic test_reset_mid();
    do_write(4'd12, 8'hEE);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    total++;
    if (busy0 !== 1'b1) $display("FAIL mid_reset_busy: got %b exp 1", busy0); else passed++;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if (busy0 !== (k < 16)) $display("FAIL mid_sweep_busy edge %0d: got %b exp %b", k, busy0, (k < 16));
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      rd_enable = 1'b1; addr = AW'(i);
      tick();
      total++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== INIT)
        $display("FAIL mid_read addr %0d: got v=%b d=%h exp v=1 d=a5", i, rd_valid0, rd_data0);
      else passed++;
    end
    rd_enable = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h30;
    for (int i = 0; i < 3; i++) do_write(AW'(i), exp_d[i]);
    for (int i = 0; i < 3; i++) begin
      rd_enable = 1'b1; addr = AW'(i);
      tick();
      total++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== exp_d[i])
        $display("FAIL b2b addr %0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid0, rd_data0, exp_d[i]);
      else passed++;
    end
    rd_enable = 1'b0;
    tick();
    total++;
    if (rd_valid0 !== 1'b0 || rd_data0 !== 8'h30)
      $display("FAIL b2b_hold: got v=%b d=%h exp v=0 d=30", rd_valid0, rd_data0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
